// File: rtl/proc_err_pkg.sv
// Shared definitions for the processor error monitor: fault codes, opcode
// field position and the default legal-opcode mask.
package proc_err_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILL_OPC  = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_WDOG     = 2'd3
  } err_code_t;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Opcodes 2 and 3 are reserved encodings.
  localparam logic [31:0] DEF_LEGAL_OPC_MASK = 32'hFFFF_FFF3;

endpackage

// File: rtl/proc_err_wdog.sv
// Retire watchdog: counts consecutive idle cycles and flags when the count
// reaches the last allowed value. The caller stops enabling it once the
// fault has been taken, so it never wraps.
module proc_err_wdog #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(CYCLES) + 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Idle-cycle counter, cleared by reset or any retire.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == TC);

endmodule

// File: rtl/proc_err_mon.sv
// Processor error monitor. Watches the retire stream and data-memory
// requests and latches the first fault (illegal opcode, misaligned word
// access, retire watchdog) as a sticky error with a code and a PC.
// Build option: define PROC_ERR_MON_WDOG_EN to include the retire watchdog
// (fault code 3); without it WDOG_CYCLES has no effect.
//
// state   | meaning
// --------+-------------------------------------------------------
// RUN     | monitoring; events are detected, watchdog counting
// ERR     | fault latched; outputs frozen until rst
// HALTED  | HALT retired cleanly; nothing detected until rst
module proc_err_mon
  import proc_err_pkg::*;
#(
  parameter logic [31:0] LEGAL_OPC_MASK = DEF_LEGAL_OPC_MASK,
  parameter int unsigned WDOG_CYCLES    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ret_valid,
  input  logic [15:0] ret_instr,
  input  logic [15:0] ret_pc,
  input  logic        ret_halt,
  input  logic        mem_en,
  input  logic [15:0] mem_addr,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] err_pc
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ERR    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] last_pc;

  logic [OPC_W-1:0] opc;
  logic             ill_evt;
  logic             mis_evt;
  logic             wdog_evt;
  logic             run;

  // Only the opcode field and the byte-select bit matter here.
  logic unused_bits;
  assign unused_bits = ^{ret_instr[OPC_LSB-1:0], mem_addr[15:1]};

  assign run     = (state == ST_RUN);
  assign opc     = ret_instr[OPC_MSB:OPC_LSB];
  assign ill_evt = ret_valid && !LEGAL_OPC_MASK[opc];
  assign mis_evt = mem_en && mem_addr[0];

  // A watchdog shorter than two cycles cannot distinguish a retire from idle.
  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("proc_err_mon: WDOG_CYCLES must be at least 2");
  end

`ifdef PROC_ERR_MON_WDOG_EN
  logic wdog_expire;

  proc_err_wdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .clear  (rst || (run && ret_valid)),
    .enable (run && !ret_valid),
    .expire (wdog_expire)
  );

  assign wdog_evt = run && wdog_expire && !ret_valid;
`else
  assign wdog_evt = 1'b0;
`endif

  // Monitor FSM with registered, sticky fault outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      err_pc   <= '0;
      last_pc  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ret_valid) begin
            last_pc <= ret_pc;
          end
          if (ill_evt) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_ILL_OPC;
            err_pc   <= ret_pc;
          end else if (mis_evt) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_MISALIGN;
            err_pc   <= last_pc;
          end else if (wdog_evt) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_WDOG;
            err_pc   <= last_pc;
          end else if (ret_valid && ret_halt) begin
            state <= ST_HALTED;
          end
        end
        ST_ERR:    state <= ST_ERR;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_err_mon.sv
// Directed bench for proc_err_mon with WDOG_CYCLES=8. Watchdog expectations
// follow PROC_ERR_MON_WDOG_EN as seen by this compilation.
module tb_proc_err_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic        ret_valid;
  logic [15:0] ret_instr;
  logic [15:0] ret_pc;
  logic        ret_halt;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] err_pc;

  int n_checks = 0;
  int n_errors = 0;

  proc_err_mon #(
    .LEGAL_OPC_MASK (32'hFFFF_FFF3),
    .WDOG_CYCLES    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ret_valid (ret_valid),
    .ret_instr (ret_instr),
    .ret_pc    (ret_pc),
    .ret_halt  (ret_halt),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .err       (err),
    .err_code  (err_code),
    .err_pc    (err_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e, input logic [1:0] c, input logic [15:0] pc);
    check({tag, ".err"}, 32'(err), 32'(e));
    check({tag, ".code"}, 32'(err_code), 32'(c));
    check({tag, ".pc"}, 32'(err_pc), 32'(pc));
  endtask

  task automatic idle_inputs();
    ret_valid = 1'b0;
    ret_instr = 16'h0000;
    ret_pc    = 16'h0000;
    ret_halt  = 1'b0;
    mem_en    = 1'b0;
    mem_addr  = 16'h0000;
  endtask

  // Apply current inputs at the next rising edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic retire(input logic [15:0] instr, input logic [15:0] pc, input logic halt);
    ret_valid = 1'b1;
    ret_instr = instr;
    ret_pc    = pc;
    ret_halt  = halt;
  endtask

  task automatic mem(input logic [15:0] addr);
    mem_en   = 1'b1;
    mem_addr = addr;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    step();
    rst = 1'b0;
    check_out("reset", 1'b0, 2'd0, 16'h0000);

    // Legal retire of opcode 1.
    retire(16'h0800, 16'h0010, 1'b0); step();
    check_out("legal_op1", 1'b0, 2'd0, 16'h0000);
    mem(16'h0102); step();
    check_out("aligned_mem", 1'b0, 2'd0, 16'h0000);

    // Illegal opcode 2, then later events must not disturb the latch.
    retire(16'h1000, 16'h0042, 1'b0); step();
    check_out("ill_op2", 1'b1, 2'd1, 16'h0042);
    mem(16'h0101); step();
    check_out("err_frozen_mis", 1'b1, 2'd1, 16'h0042);
    retire(16'h1800, 16'h0055, 1'b0); step();
    check_out("err_frozen_ill", 1'b1, 2'd1, 16'h0042);

    // Reset out of ERR with an illegal retire presented in the reset cycle.
    rst = 1'b1; retire(16'h1000, 16'h0066, 1'b0); step(); rst = 1'b0;
    check_out("rst_from_err", 1'b0, 2'd0, 16'h0000);
    mem(16'h0001); step();
    check_out("resume_mis_lastpc0", 1'b1, 2'd2, 16'h0000);

    // Misaligned after a retire reports the retire PC.
    do_reset();
    retire(16'h0800, 16'h0020, 1'b0); step();
    mem(16'h0103); step();
    check_out("misalign", 1'b1, 2'd2, 16'h0020);

    // Illegal opcode beats misaligned in the same cycle.
    do_reset();
    retire(16'h0800, 16'h0020, 1'b0); step();
    retire(16'h1000, 16'h0024, 1'b0); mem(16'h0103); step();
    check_out("ill_beats_mis", 1'b1, 2'd1, 16'h0024);

    // Opcode boundaries: 3 illegal, 4 and 31 legal.
    do_reset();
    retire(16'h2000, 16'h0100, 1'b0); step();
    retire(16'hF800, 16'h0102, 1'b0); step();
    check_out("legal_op4_op31", 1'b0, 2'd0, 16'h0000);
    retire(16'h1800, 16'h0104, 1'b0); step();
    check_out("ill_op3", 1'b1, 2'd1, 16'h0104);

`ifdef PROC_ERR_MON_WDOG_EN
    // Watchdog fires on the 8th idle cycle after the last retire.
    do_reset();
    retire(16'h0800, 16'h0030, 1'b0); step();
    idle(7);
    check_out("wdog_7idle", 1'b0, 2'd0, 16'h0000);
    idle(1);
    check_out("wdog_fire", 1'b1, 2'd3, 16'h0030);

    // A retire in the 8th cycle prevents the fault and restarts the count.
    do_reset();
    retire(16'h0800, 16'h0030, 1'b0); step();
    idle(7);
    retire(16'h0800, 16'h0034, 1'b0); step();
    check_out("wdog_saved", 1'b0, 2'd0, 16'h0000);
    idle(7);
    check_out("wdog_saved_7idle", 1'b0, 2'd0, 16'h0000);
    idle(1);
    check_out("wdog_refire", 1'b1, 2'd3, 16'h0034);

    // Misaligned beats watchdog in the firing cycle.
    do_reset();
    idle(7);
    mem(16'h0005); step();
    check_out("mis_beats_wdog", 1'b1, 2'd2, 16'h0000);
`else
    do_reset();
    retire(16'h0800, 16'h0030, 1'b0); step();
    idle(100);
    check_out("no_wdog_100idle", 1'b0, 2'd0, 16'h0000);
`endif

    // HALT: nothing detected afterwards.
    do_reset();
    retire(16'h0800, 16'h0040, 1'b1); step();
    check_out("halt", 1'b0, 2'd0, 16'h0000);
    idle(2000);
    mem(16'h0103); step();
    check_out("halted_mis", 1'b0, 2'd0, 16'h0000);
    retire(16'h1000, 16'h0044, 1'b0); step();
    check_out("halted_ill", 1'b0, 2'd0, 16'h0000);

    // Error in the HALT retire cycle wins.
    do_reset();
    retire(16'h0800, 16'h0050, 1'b0); step();
    retire(16'h0800, 16'h0052, 1'b1); mem(16'h0201); step();
    check_out("halt_vs_mis", 1'b1, 2'd2, 16'h0050);
    do_reset();
    retire(16'h1000, 16'h0060, 1'b1); step();
    check_out("halt_vs_ill", 1'b1, 2'd1, 16'h0060);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
